// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input, and the decode handshake.
// The master side belongs to fetch_unit.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        halted;
  logic [15:0] stall_cnt;

  modport master (
    output imem_addr, if_valid, if_inst, if_pc, if_pc_plus4, halted, stall_cnt,
    input  imem_inst, br_taken, br_addr, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_inst, if_pc, if_pc_plus4, halted, stall_cnt,
    output imem_inst, br_taken, br_addr, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, captures memory words into a 2-entry
// in-order buffer feeding decode, handles branch flush and the end-of-program halt.
//
// state   | meaning
// FETCH   | pushing one word per cycle while the buffer has room
// HALT    | PC at or past the end of memory; buffer drains, only a redirect leaves
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;

  localparam logic [32:0] LIMIT       = 33'(MEM_WORDS) * 33'd4;
  localparam state_t      RESET_STATE = ({1'b0, RESET_PC} >= LIMIT) ? S_HALT : S_FETCH;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [1:0]  cnt_q;
  logic [31:0] inst_q [2];
  logic [31:0] epc_q  [2];
  logic [15:0] stall_q;

  logic        valid;
  logic        pop;
  logic        push;
  logic [31:0] pc_inc;
  logic [31:0] br_tgt;

  assign valid  = (cnt_q != 2'd0);
  assign pop    = valid & bus.id_ready;
  assign push   = (state_q == S_FETCH) & ((cnt_q < 2'd2) | pop) & ~bus.br_taken;
  assign pc_inc = pc_q + 32'd4;
  assign br_tgt = {bus.br_addr[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      pc_q      <= RESET_PC;
      cnt_q     <= 2'd0;
      inst_q[0] <= '0;
      inst_q[1] <= '0;
      epc_q[0]  <= '0;
      epc_q[1]  <= '0;
      stall_q   <= '0;
    end else begin
      if (valid && !bus.id_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;

      if (bus.br_taken) begin
        cnt_q   <= 2'd0;
        pc_q    <= br_tgt;
        state_q <= ({1'b0, br_tgt} >= LIMIT) ? S_HALT : S_FETCH;
      end else begin
        if (push) begin
          pc_q <= pc_inc;
          // pc_inc is the wrapped value, so a full-space memory wraps to 0 instead of halting
          if ({1'b0, pc_inc} >= LIMIT)
            state_q <= S_HALT;
        end
        case ({push, pop})
          2'b10: begin
            inst_q[cnt_q[0]] <= bus.imem_inst;
            epc_q[cnt_q[0]]  <= pc_q;
            cnt_q            <= cnt_q + 2'd1;
          end
          2'b01: begin
            inst_q[0] <= inst_q[1];
            epc_q[0]  <= epc_q[1];
            cnt_q     <= cnt_q - 2'd1;
          end
          2'b11: begin
            if (cnt_q == 2'd1) begin
              inst_q[0] <= bus.imem_inst;
              epc_q[0]  <= pc_q;
            end else begin
              inst_q[0] <= inst_q[1];
              epc_q[0]  <= epc_q[1];
              inst_q[1] <= bus.imem_inst;
              epc_q[1]  <= pc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = valid;
  assign bus.if_inst     = valid ? inst_q[0] : 32'd0;
  assign bus.if_pc       = valid ? epc_q[0] : 32'd0;
  assign bus.if_pc_plus4 = valid ? (epc_q[0] + 32'd4) : 32'd0;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an 8-word combinational instruction memory
// holding Wk = 32'hA000_0000 + k.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WORDS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_inst = (bus.imem_addr < 32'd32) ?
                         (32'hA000_0000 + {29'd0, bus.imem_addr[4:2]}) : 32'hBAD0_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Assert reset during the low phase and release before the next rising edge,
  // so that edge captures the word at RESET_PC.
  task automatic do_reset(input logic ready);
    @(negedge clk);
    bus.id_ready = ready;
    bus.br_taken = 1'b0;
    bus.br_addr  = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n        = 1'b0;
    bus.id_ready = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_addr  = '0;

    #2;
    chk("rst_valid",  {31'd0, bus.if_valid}, 32'd0);
    chk("rst_addr",   bus.imem_addr, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_stall",  {16'd0, bus.stall_cnt}, 32'd0);
    chk("rst_inst",   bus.if_inst, 32'd0);
    chk("rst_pc4",    bus.if_pc_plus4, 32'd0);

    // Streaming run to the end of memory
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("seq_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("seq_pc",    bus.if_pc, 32'(4 * k));
      chk("seq_inst",  bus.if_inst, 32'hA000_0000 + 32'(k));
      chk("seq_pc4",   bus.if_pc_plus4, 32'(4 * k + 4));
    end
    chk("seq_halted", {31'd0, bus.halted}, 32'd1);
    @(negedge clk);
    chk("seq_drained", {31'd0, bus.if_valid}, 32'd0);
    chk("seq_halt_hold", bus.imem_addr, 32'd32);

    // Back-pressure: decode stalls for 5 valid cycles
    do_reset(1'b0);
    @(negedge clk);
    chk("bp_first", bus.if_pc, 32'd0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("bp_stall",  {16'd0, bus.stall_cnt}, 32'd5);
    chk("bp_pchold", bus.imem_addr, 32'd8);
    chk("bp_head",   bus.if_pc, 32'd0);
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("bp_pc4", bus.if_pc, 32'd4);
    @(negedge clk);
    chk("bp_pc8", bus.if_pc, 32'd8);
    chk("bp_inst8", bus.if_inst, 32'hA000_0002);
    @(negedge clk);
    chk("bp_pc12", bus.if_pc, 32'd12);
    chk("bp_stall_kept", {16'd0, bus.stall_cnt}, 32'd5);

    // Redirect while full, unaligned target
    bus.id_ready = 1'b0;
    bus.br_taken = 1'b1;
    bus.br_addr  = 32'h0000_0012;
    @(negedge clk);
    chk("br_flush", {31'd0, bus.if_valid}, 32'd0);
    chk("br_addr",  bus.imem_addr, 32'h10);
    chk("br_stall", {16'd0, bus.stall_cnt}, 32'd6);
    bus.br_taken = 1'b0;
    @(negedge clk);
    chk("br_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("br_pc",    bus.if_pc, 32'h10);
    chk("br_pc4",   bus.if_pc_plus4, 32'h14);
    chk("br_inst",  bus.if_inst, 32'hA000_0004);

    // Leave HALT with a redirect, then redirect out of range
    do_reset(1'b1);
    for (int k = 0; k < 9; k++) @(negedge clk);
    chk("h_halted", {31'd0, bus.halted}, 32'd1);
    chk("h_empty",  {31'd0, bus.if_valid}, 32'd0);
    bus.br_taken = 1'b1;
    bus.br_addr  = 32'd4;
    @(negedge clk);
    bus.br_taken = 1'b0;
    chk("h_resume", {31'd0, bus.halted}, 32'd0);
    chk("h_bubble", {31'd0, bus.if_valid}, 32'd0);
    @(negedge clk);
    chk("h_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("h_pc",    bus.if_pc, 32'd4);
    chk("h_inst",  bus.if_inst, 32'hA000_0001);
    bus.br_taken = 1'b1;
    bus.br_addr  = 32'h40;
    @(negedge clk);
    bus.br_taken = 1'b0;
    chk("oor_halted", {31'd0, bus.halted}, 32'd1);
    chk("oor_addr",   bus.imem_addr, 32'h40);
    for (int k = 0; k < 3; k++) begin
      chk("oor_novalid", {31'd0, bus.if_valid}, 32'd0);
      @(negedge clk);
    end
    chk("oor_novalid_end", {31'd0, bus.if_valid}, 32'd0);

    // Asynchronous reset with a full buffer
    do_reset(1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("ar_full_pc",  bus.imem_addr, 32'd8);
    chk("ar_stall_pre", {16'd0, bus.stall_cnt}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("ar_pc",    bus.imem_addr, 32'd0);
    chk("ar_stall", {16'd0, bus.stall_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer for the single-issue lab processor. It owns the program counter, drives the word address into the combinational instruction memory, and captures each returned word into a 2-entry fetch buffer. The buffer feeds decode through a valid/ready handshake. Branch redirects flush the buffer, and an end-of-program guard halts fetching.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; word-aligned
- MEM_WORDS, 8: instruction memory depth in words; fetch limit is MEM_WORDS*4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- imem_addr  output  32  byte address to instruction memory; equals pc_q
- imem_inst  input  32  instruction word, combinationally valid in the same cycle as imem_addr
- br_taken  input  1  redirect request from execute
- br_addr  input  32  redirect target; bits [1:0] forced to 0
- id_ready  input  1  decode accepts the head entry this cycle
- if_valid  output  1  head entry present
- if_inst  output  32  head instruction
- if_pc  output  32  head instruction address
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32
- halted  output  1  state is HALT
- stall_cnt  output  16  cycles with if_valid=1 and id_ready=0; saturates at 16'hFFFF

## Operation
- State register has two states: FETCH and HALT. Reset state: FETCH, or HALT if RESET_PC >= MEM_WORDS*4.
- Reset values (asynchronous, rst_n=0):
  - pc_q=RESET_PC
  - buffer count=0, so if_valid=0
  - if_inst, if_pc and if_pc_plus4 read 0 while empty
  - halted per reset state
  - stall_cnt=0
- pop = if_valid & id_ready.
- push = (state==FETCH) & (count<2 | pop) & ~br_taken.
- On push:
  - Write {pc_q, imem_inst} at the buffer tail.
  - pc_q <= pc_q+4.
  - If pc_q+4 >= MEM_WORDS*4, go to HALT.
- Push and pop in the same cycle leave count unchanged. Entries stay in order; the head is the oldest entry.
- br_taken has the highest priority:
  - count <= 0 (any simultaneous pop is dropped).
  - pc_q <= {br_addr[31:2],2'b00}.
  - Next state is FETCH if that target < MEM_WORDS*4, else HALT.
  - No push occurs in the redirect cycle.
- HALT:
  - No pushes; the buffer drains normally through pops.
  - pc_q holds its value.
  - Only br_taken leaves HALT.
- stall_cnt increments on each cycle with if_valid & ~id_ready. It saturates at 16'hFFFF and is not cleared by br_taken.
- Outputs if_valid, if_inst, if_pc, if_pc_plus4 and halted are decoded from registers only, with no combinational path from inputs. imem_addr = pc_q.

## Timing
- Fetch latency: an instruction at pc_q in cycle N appears as if_valid/if_inst in cycle N+1 if the buffer was empty.
- After rst_n deasserts, the first edge captures instruction 0. if_valid=1 from the next cycle.
- Throughput is 1 instruction/cycle while id_ready=1 continuously.
- The buffer is full at count=2:
  - With id_ready=0, no push occurs and pc_q holds.
  - With id_ready=1, push and pop occur together.
- br_taken asserted in cycle N:
  - Cycle N+1: if_valid=0, imem_addr=target.
  - Cycle N+2: the target instruction is valid (2-cycle redirect bubble).
- br_taken held for consecutive cycles: each cycle re-flushes and reloads pc_q; the last target wins.
- Wrap-around: pc_q+4 overflow past 32'hFFFF_FFFC wraps to 0. That value is only reachable with MEM_WORDS covering the full space; otherwise the HALT guard applies first.
- An asynchronous reset mid-operation discards buffer contents immediately; there is no partial state.

## Test plan
- Reset release, id_ready=1, memory words W0..W7, MEM_WORDS=8:
  - if_pc sequence 0,4,...,28 on consecutive cycles with if_inst=W0..W7.
  - halted=1 after the fetch at 28; if_valid=0 from the cycle after W7 is consumed.
- id_ready=0 for 5 cycles after the first valid:
  - count reaches 2 and pc_q holds at 8.
  - stall_cnt=5.
  - Releasing id_ready delivers pc 0,4,8 in order with no loss or duplicate.
- br_taken with br_addr=32'h0000_0012 while the buffer is full:
  - Next cycle if_valid=0 and imem_addr=32'h10.
  - The following cycle if_pc=32'h10 and if_pc_plus4=32'h14.
- While halted with the buffer empty, br_taken with br_addr=4:
  - halted=0 next cycle.
  - Fetch resumes at 4; W1 is valid two cycles after br_taken.
- br_taken with br_addr=32'h40 (>= 32): halted=1, no further if_valid.
- rst_n pulsed low mid-stream with count=2: if_valid=0, pc_q=0 and stall_cnt=0 immediately, asynchronously, without waiting for clk.
